// File: rtl/count_enable_gen_pkg.sv
// Shared constants for the count-enable generator, used by board tops and benches.
package count_enable_gen_pkg;

  typedef enum logic {
    MODE_STEP = 1'b0,
    MODE_RUN  = 1'b1
  } mode_e;

  localparam int unsigned CLK_HZ                  = 50000000;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEFAULT_TICK_DIV        = 50000000;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser and stable-count debouncer for an active-low pushbutton;
// also provides a one-cycle press strobe on each debounced press.
module key_debouncer
  import count_enable_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic clear,
  input  logic key_n,
  output logic pressed,
  output logic press
);

  localparam int unsigned      DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            key_s;
  logic            pressed_q;
  logic [DB_W-1:0] db_cnt;

  assign key_s = ~sync2;
  assign press = pressed & ~pressed_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      db_cnt    <= '0;
      pressed   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      pressed_q <= pressed;
      // Any return to the current level restarts qualification.
      if (key_s == pressed) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        pressed <= key_s;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Count-enable pulse generator: one Tick per debounced press (step mode) or
// one Tick every TICK_DIV cycles (free-run mode), gated by Run.
module count_enable_gen
  import count_enable_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_DIV        = DEFAULT_TICK_DIV
) (
  input  logic Clock,
  input  logic Clear,
  input  logic Key_n,
  input  logic Mode,
  input  logic Run,
  output logic Tick,
  output logic Pressed
);

  localparam int unsigned      DIV_W    = cnt_width(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic             press;
  logic             mode_chg;
  mode_e            mode_q;
  logic [DIV_W-1:0] div_cnt;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (Clock),
    .clear  (Clear),
    .key_n  (Key_n),
    .pressed(Pressed),
    .press  (press)
  );

  assign mode_chg = (Mode != logic'(mode_q));

  always_ff @(posedge Clock) begin
    if (Clear) begin
      Tick    <= 1'b0;
      div_cnt <= '0;
      mode_q  <= MODE_STEP;
    end else begin
      mode_q <= mode_e'(Mode);
      if (mode_chg) begin
        div_cnt <= '0;
        Tick    <= 1'b0;
      end else if (mode_q == MODE_STEP) begin
        Tick <= press & Run;
      end else if (press) begin
        // A press in free-run realigns the divider phase to this cycle.
        div_cnt <= '0;
        Tick    <= 1'b0;
      end else if (!Run) begin
        Tick <= 1'b0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        Tick    <= 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
        Tick    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen with DEBOUNCE_CYCLES=4, TICK_DIV=5.
module tb_count_enable_gen;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 5;

  logic clk = 1'b0;
  logic Clear, Key_n, Mode, Run;
  logic Tick, Pressed;

  typedef struct {
    int   cyc;
    logic lvl;
  } pev_t;

  int   tick_q[$];
  pev_t press_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic prev_pressed = 1'b0;

  count_enable_gen #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_DIV       (DIV)
  ) dut (
    .Clock  (clk),
    .Clear  (Clear),
    .Key_n  (Key_n),
    .Mode   (Mode),
    .Run    (Run),
    .Tick   (Tick),
    .Pressed(Pressed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every Tick pulse and every Pressed edge is matched to the scoreboard.
  initial begin
    int   e;
    pev_t p;
    forever begin
      @(negedge clk);
      if (Tick === 1'b1) begin
        compared++;
        if (tick_q.size() == 0) begin
          mismatched++;
          $display("FAIL tick_unexpected: Tick high after edge %0d, none expected", cyc);
        end else begin
          e = tick_q.pop_front();
          if (e != cyc) begin
            mismatched++;
            $display("FAIL tick_cycle: Tick after edge %0d, expected after edge %0d", cyc, e);
          end
        end
      end
      if (Pressed !== prev_pressed) begin
        compared++;
        if (press_q.size() == 0) begin
          mismatched++;
          $display("FAIL pressed_unexpected: Pressed=%b after edge %0d, no change expected",
                   Pressed, cyc);
        end else begin
          p = press_q.pop_front();
          if (p.cyc != cyc || p.lvl !== Pressed) begin
            mismatched++;
            $display("FAIL pressed_edge: Pressed=%b after edge %0d, expected %b after edge %0d",
                     Pressed, cyc, p.lvl, p.cyc);
          end
        end
        prev_pressed = Pressed;
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_pressed(input int c, input logic l);
    pev_t p;
    p.cyc = c;
    p.lvl = l;
    press_q.push_back(p);
  endtask

  // Clean press held for 'hold' cycles, then released and allowed to settle.
  task automatic clean_press(input int hold, input bit ticks);
    int t;
    t = cyc;
    Key_n = 1'b0;
    exp_pressed(t + DB + 2, 1'b1);
    if (ticks) tick_q.push_back(t + DB + 3);
    wait_cyc(t + hold);
    Key_n = 1'b1;
    exp_pressed(t + hold + DB + 2, 1'b0);
    wait_cyc(t + hold + DB + 6);
  endtask

  task automatic check_reset;
    compared++;
    if (Tick !== 1'b0 || Pressed !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: Tick=%b Pressed=%b, required 0/0", Tick, Pressed);
    end
  endtask

  initial begin
    int t0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    Clear = 1'b1;
    Key_n = 1'b0;
    Mode  = 1'b0;
    Run   = 1'b1;

    // Reset with key held: outputs stay low, key is re-qualified afterwards.
    @(negedge clk); check_reset();
    @(negedge clk); check_reset();
    Clear = 1'b0;
    exp_pressed(cyc + DB + 2, 1'b1);
    tick_q.push_back(cyc + DB + 3);
    wait_cyc(22);
    Key_n = 1'b1;
    exp_pressed(22 + DB + 2, 1'b0);
    wait_cyc(32);

    // Step mode: one tick for a long clean press, none on release.
    clean_press(20, 1'b1);

    // Bounce: 0,1,0,1 at 2-cycle spacing, then low.
    t0 = cyc;
    Key_n = 1'b0; wait_cyc(t0 + 2);
    Key_n = 1'b1; wait_cyc(t0 + 4);
    Key_n = 1'b0; wait_cyc(t0 + 6);
    Key_n = 1'b1; wait_cyc(t0 + 8);
    Key_n = 1'b0;
    exp_pressed(t0 + 8 + DB + 2, 1'b1);
    tick_q.push_back(t0 + 8 + DB + 3);
    wait_cyc(t0 + 28);
    Key_n = 1'b1;
    exp_pressed(t0 + 28 + DB + 2, 1'b0);
    wait_cyc(t0 + 38);

    // Free-run: settle the mode change with Run low, then start at div_cnt=0.
    Mode = 1'b1;
    Run  = 1'b0;
    wait_cyc(cyc + 3);
    t0 = cyc;
    Run = 1'b1;
    for (int unsigned k = 1; k <= 5; k++) tick_q.push_back(t0 + 5 * int'(k));
    wait_cyc(t0 + 27);
    Run = 1'b0;                   // div_cnt = 2, held for 3 cycles
    wait_cyc(t0 + 30);
    Run = 1'b1;
    tick_q.push_back(t0 + 33);
    tick_q.push_back(t0 + 38);
    // Realign: press qualifies with div_cnt=3, tick that would come at +43 moves to +47.
    wait_cyc(t0 + 35);
    Key_n = 1'b0;
    exp_pressed(t0 + 41, 1'b1);
    tick_q.push_back(t0 + 47);
    tick_q.push_back(t0 + 52);
    tick_q.push_back(t0 + 57);
    wait_cyc(t0 + 50);
    Key_n = 1'b1;
    exp_pressed(t0 + 56, 1'b0);
    // Mode toggle with div_cnt=3: changes at edges +61 and +62 both zero div_cnt.
    wait_cyc(t0 + 60);
    Mode = 1'b0;
    wait_cyc(t0 + 61);
    Mode = 1'b1;
    tick_q.push_back(t0 + 67);
    wait_cyc(t0 + 70);
    Run  = 1'b0;
    Mode = 1'b0;
    wait_cyc(t0 + 76);

    // Run gate: presses in step mode with Run low produce no ticks.
    for (int unsigned k = 0; k < 3; k++) clean_press(8, 1'b0);

    wait_cyc(cyc + 10);
    compared++;
    if (tick_q.size() != 0) begin
      mismatched++;
      $display("FAIL tick_missing: %0d expected ticks never seen, required 0", tick_q.size());
    end
    compared++;
    if (press_q.size() != 0) begin
      mismatched++;
      $display("FAIL pressed_missing: %0d expected Pressed edges never seen, required 0",
               press_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
